stream_upsizer: RTL and testbench

- Valid/ready width converter. Packs RATIO consecutive DATA_WIDTH beats into one DATA_WIDTH*RATIO word.
- Sits directly downstream of the single-entry pipeline register and consumes its output stream.
- Emits wide words to the wide-datapath stages.
- in_last forces early emission of a partial group, with a lane-valid mask.

---
 rtl/stream_upsizer.sv | 86 ++++++++
 tb/tb_stream_upsizer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/stream_upsizer.sv
// rtl/stream_upsizer.sv - packs RATIO narrow beats into one wide word with lane-valid mask
module stream_upsizer #(
    parameter int DATA_WIDTH = 32,
    parameter int RATIO      = 4,
    parameter int IDX_W      = $clog2(RATIO)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]            out_keep,
    output logic                        out_last
);

    localparam int OUT_W = DATA_WIDTH * RATIO;

    generate
        if (RATIO < 2) begin : g_bad_ratio
            $error("stream_upsizer: RATIO must be 2 or more");
        end
    endgenerate

    logic [OUT_W-1:0] acc;
    logic [IDX_W-1:0] idx;
    logic             in_fire;
    logic             out_fire;
    logic             idx_full;
    logic             completing;
    logic [OUT_W-1:0] next_data;
    logic [RATIO-1:0] next_keep;

    assign in_ready   = ~out_valid | out_ready;
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;
    assign idx_full   = (idx == IDX_W'(RATIO - 1));
    assign completing = in_fire & (idx_full | in_last);

    // Lanes above idx are forced to zero so a short group never leaks stale data.
    always_comb begin
        next_data = '0;
        next_keep = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (IDX_W'(k) < idx) begin
                next_data[k*DATA_WIDTH +: DATA_WIDTH] = acc[k*DATA_WIDTH +: DATA_WIDTH];
                next_keep[k] = 1'b1;
            end else if (IDX_W'(k) == idx) begin
                next_data[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
                next_keep[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (completing) begin
                out_data  <= next_data;
                out_keep  <= next_keep;
                out_last  <= in_last;
                out_valid <= 1'b1;
                acc       <= '0;
                idx       <= '0;
            end else begin
                if (in_fire) begin
                    acc[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                    idx <= idx + IDX_W'(1);
                end
                if (out_fire) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_upsizer.sv
// tb/tb_stream_upsizer.sv - directed vector bench for stream_upsizer
module tb_stream_upsizer;

    localparam int DW = 32;
    localparam int R  = 4;
    localparam int OW = DW * R;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [R-1:0]  out_keep;
    logic          out_last;

    int total = 0;
    int bad   = 0;
    logic rdy_s;

    always #5 clk = ~clk;

    stream_upsizer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          l;
        logic          ordy;
        logic          exp_rdy;
        logic          exp_ov;
        logic [OW-1:0] exp_data;
        logic [R-1:0]  exp_keep;
        logic          exp_last;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, sample in_ready mid-cycle, then advance past the edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic ordy);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        #1;
        rdy_s = in_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [OW-1:0] held;
        logic [OW-1:0] word;
        int hs;
        int rdy_low;

        vecs[0] = '{1'b1, 32'h11111111, 1'b0, 1'b1, 1'b1, 1'b0, '0, 4'h0, 1'b0};
        vecs[1] = '{1'b1, 32'h22222222, 1'b0, 1'b1, 1'b1, 1'b0, '0, 4'h0, 1'b0};
        vecs[2] = '{1'b1, 32'h33333333, 1'b0, 1'b1, 1'b1, 1'b0, '0, 4'h0, 1'b0};
        vecs[3] = '{1'b1, 32'h44444444, 1'b0, 1'b1, 1'b1, 1'b1,
                    {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 4'b1111, 1'b0};
        vecs[4] = '{1'b1, 32'h0000000A, 1'b0, 1'b1, 1'b1, 1'b0, '0, 4'h0, 1'b0};
        vecs[5] = '{1'b1, 32'h0000000B, 1'b1, 1'b1, 1'b1, 1'b1,
                    {32'h0, 32'h0, 32'h0000000B, 32'h0000000A}, 4'b0011, 1'b1};
        vecs[6] = '{1'b1, 32'h0000000C, 1'b1, 1'b1, 1'b1, 1'b1,
                    {32'h0, 32'h0, 32'h0, 32'h0000000C}, 4'b0001, 1'b1};
        vecs[7] = '{1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, '0, 4'h0, 1'b0};
        vecs[8] = '{1'b1, 32'h000000E1, 1'b1, 1'b1, 1'b1, 1'b1,
                    {32'h0, 32'h0, 32'h0, 32'h000000E1}, 4'b0001, 1'b1};

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("reset out_valid", OW'(out_valid), OW'(1'b0));
        check("reset out_data", out_data, '0);
        check("reset out_keep", OW'(out_keep), '0);
        check("reset out_last", OW'(out_last), '0);
        check("reset in_ready", OW'(in_ready), OW'(1'b1));
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].ordy);
            check($sformatf("vec%0d in_ready", i), OW'(rdy_s), OW'(vecs[i].exp_rdy));
            check($sformatf("vec%0d out_valid", i), OW'(out_valid), OW'(vecs[i].exp_ov));
            if (vecs[i].exp_ov) begin
                check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
                check($sformatf("vec%0d out_keep", i), OW'(out_keep), OW'(vecs[i].exp_keep));
                check($sformatf("vec%0d out_last", i), OW'(out_last), OW'(vecs[i].exp_last));
            end
        end
        step(1'b0, '0, 1'b0, 1'b1);

        // Backpressure: full word held, pending beat must wait and then be taken.
        for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0, 1'b1);
        held = {32'h4, 32'h3, 32'h2, 32'h1};
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 32'h55, 1'b0, 1'b0);
            check($sformatf("bp%0d in_ready", k), OW'(rdy_s), OW'(1'b0));
            check($sformatf("bp%0d out_valid", k), OW'(out_valid), OW'(1'b1));
            check($sformatf("bp%0d out_data", k), out_data, held);
            check($sformatf("bp%0d out_keep", k), OW'(out_keep), OW'(4'b1111));
            check($sformatf("bp%0d out_last", k), OW'(out_last), OW'(1'b0));
        end
        step(1'b1, 32'h55, 1'b0, 1'b1);
        check("bp release in_ready", OW'(rdy_s), OW'(1'b1));
        check("bp release out_valid", OW'(out_valid), OW'(1'b0));
        step(1'b1, 32'h66, 1'b1, 1'b1);
        check("bp next out_valid", OW'(out_valid), OW'(1'b1));
        check("bp next out_data", out_data, {32'h0, 32'h0, 32'h66, 32'h55});
        check("bp next out_keep", OW'(out_keep), OW'(4'b0011));
        check("bp next out_last", OW'(out_last), OW'(1'b1));
        step(1'b0, '0, 1'b0, 1'b1);

        // Streaming: 12 beats back to back with out_ready high.
        hs = 0;
        rdy_low = 0;
        for (int c = 0; c <= 12; c++) begin
            in_valid  = (c < 12);
            in_data   = DW'(32'h1000 + c);
            in_last   = 1'b0;
            out_ready = 1'b1;
            #1;
            if (c < 12 && !in_ready) rdy_low++;
            if (out_valid && out_ready) begin
                word = {DW'(32'h1000 + 4*hs + 3), DW'(32'h1000 + 4*hs + 2),
                        DW'(32'h1000 + 4*hs + 1), DW'(32'h1000 + 4*hs)};
                check($sformatf("stream word%0d", hs), out_data, word);
                check($sformatf("stream keep%0d", hs), OW'(out_keep), OW'(4'b1111));
                hs++;
            end
            @(posedge clk); #1;
        end
        check("stream handshakes", OW'(hs), OW'(3));
        check("stream in_ready low count", OW'(rdy_low), OW'(0));

        // Reset mid-group discards the partial beats.
        step(1'b1, 32'h77, 1'b0, 1'b1);
        step(1'b1, 32'h88, 1'b0, 1'b1);
        reset = 1'b1;
        step(1'b0, '0, 1'b0, 1'b1);
        reset = 1'b0;
        #1;
        check("midrst out_valid", OW'(out_valid), OW'(1'b0));
        check("midrst out_data", out_data, '0);
        check("midrst out_keep", OW'(out_keep), '0);
        check("midrst in_ready", OW'(in_ready), OW'(1'b1));
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) step(1'b1, DW'(32'h91 + i), 1'b0, 1'b1);
        check("midrst word out_valid", OW'(out_valid), OW'(1'b1));
        check("midrst word out_data", out_data, {32'h94, 32'h93, 32'h92, 32'h91});
        check("midrst word out_keep", OW'(out_keep), OW'(4'b1111));
        check("midrst word out_last", OW'(out_last), OW'(1'b0));
        step(1'b0, '0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
